quadrant_serial_reader: RTL and testbench
=========================================

Name: quadrant_serial_reader

Overview:
- Read-out engine for the quadrant byte memory that the OV7670 capture path fills.
- On `iniciar`, sends a start-of-frame byte, then every stored quadrant byte in row-major order over an 8N1 UART line to the host.
- Owns the memory read port and the serial TX pin.
- Contains its own control FSM, quadrant counters and bit serializer.

Parameters:
- N_LIN, 3, number of quadrant rows.
- N_COL, 3, number of quadrant columns.
- ADDR_W, 4, memory address width; must satisfy 2^ADDR_W >= N_LIN*N_COL.
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200).
- SOF_BYTE, 8'hAA, start-of-frame byte sent before the data.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request; sampled only in state inicial.
- rd_data  in  8  memory read data, valid 1 cycle after rd_en (synchronous RAM).
- rd_addr  out  ADDR_W  memory address = linha*N_COL + coluna.
- rd_en  out  1  memory read strobe.
- saida_serial  out  1  UART TX line; idle high.
- ocupado  out  1  high in every state except inicial.
- pronto  out  1  one-cycle pulse at end of frame.
- db_estado  out  4  current state code.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=inicial; linha=0, coluna=0.
  - shift register=all ones, bit counter=0, baud counter=0.
  - saida_serial=1, rd_en=0, rd_addr=0, ocupado=0, pronto=0.
- Reset mid-frame aborts at once: the line returns high without finishing the current byte, and no pronto is issued.
- States (db_estado code):
  - inicial (0): iniciar=1 -> prepara, else stay.
  - prepara (1): linha=0, coluna=0; load SOF_BYTE into the serializer -> transmite.
  - le_memoria (2): rd_en=1, rd_addr=linha*N_COL+coluna -> espera_dado.
  - espera_dado (3): rd_en=0 -> carrega.
  - carrega (4): latch rd_data into the serializer -> transmite.
  - transmite (5): shift out the 10-bit frame.
    - Bit order: start bit 0, data bits LSB first, stop bit 1.
    - Each bit is held exactly CLKS_PER_BIT cycles.
    - The first bit appears on saida_serial in the first cycle of transmite.
    - After the stop bit's last cycle -> proximo.
  - proximo (6):
    - If the byte just sent was SOF -> le_memoria with linha=coluna=0.
    - Else if coluna=N_COL-1 and linha=N_LIN-1 -> fim.
    - Else if coluna=N_COL-1: coluna=0, linha+1 -> le_memoria.
    - Else coluna+1 -> le_memoria.
  - fim (7): pronto=1 for exactly one cycle -> inicial.
  - Unused codes -> inicial; db_estado reads 4'b1111 in that case.
- The SOF-vs-data distinction uses an internal flag: set in prepara, cleared in proximo.
- saida_serial=1 in every state other than transmite. There is no gap inside a frame; between bytes the line idles high for 4 cycles (proximo, le_memoria, espera_dado, carrega).
- Address arithmetic:
  - Computed at ADDR_W bits.
  - linha width = clog2(N_LIN), coluna width = clog2(N_COL), minimum 1 bit each.
  - Counters never exceed their N-1 limit.
- iniciar outside inicial is ignored; holding iniciar high through fim starts a new frame one cycle after fim.
- Total frame time from iniciar sampled to pronto:
  - 1 (prepara) + (1+N_LIN*N_COL)*(10*CLKS_PER_BIT+1) + 3*N_LIN*N_COL + 1 cycles.
  - Defaults with CLKS_PER_BIT=4: 1 + 10*41 + 27 + 1 = 439.
- rd_data is sampled only in carrega; changes to it at any other time have no effect.

Test Plan:
- CLKS_PER_BIT=4, memory preloaded with 0x00..0x08, pulse iniciar -> UART decoder captures AA,00,01,...,08; pronto pulses once, 439 cycles after iniciar is sampled; ocupado high throughout and low after.
- Data byte 0x5A -> saida_serial sequence 0,0,1,0,1,1,0,1,0,1 with each level held 4 cycles; line high in all non-transmite cycles.
- Address sequence check (N_LIN=2, N_COL=3) -> rd_en pulses exactly 6 times with rd_addr 0,1,2,3,4,5; rd_addr never reaches 6.
- iniciar held high continuously -> back-to-back frames; state returns to prepara 2 cycles after each pronto; repeated iniciar pulses mid-frame cause no restart and no extra byte.
- Assert reset=0 during the 3rd data bit of byte 0x02 -> saida_serial=1 and db_estado=0 in the same cycle; no pronto; a new iniciar afterwards produces a complete frame starting with AA.
- Memory changes rd_data every cycle except the carrega sampling point -> transmitted bytes match the values present in carrega only.

Source files
------------

// File: rtl/quadrant_serial_reader.sv
// Quadrant memory read-out engine: sends a start-of-frame byte, then every
// quadrant byte in row-major order, over an 8N1 UART line.
`timescale 1ns/1ps
module quadrant_serial_reader #(
  parameter int         N_LIN        = 3,
  parameter int         N_COL        = 3,
  parameter int         ADDR_W       = 4,
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SOF_BYTE     = 8'hAA
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              saida_serial,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);
  localparam int LW = (N_LIN > 1) ? $clog2(N_LIN) : 1;
  localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [LW-1:0] LIN_MAX  = LW'(N_LIN - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(N_COL - 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    LE_MEMORIA  = 4'd2,
    ESPERA_DADO = 4'd3,
    CARREGA     = 4'd4,
    TRANSMITE   = 4'd5,
    PROXIMO     = 4'd6,
    FIM         = 4'd7
  } estado_t;

  estado_t           estado_q;
  logic [LW-1:0]     linha_q, linha_d;
  logic [CW-1:0]     coluna_q, coluna_d;
  logic [9:0]        shift_q;
  logic [3:0]        bit_q;
  logic [BW-1:0]     baud_q;
  logic              sof_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q, addr_d;
  logic              ocupado_q;
  logic              pronto_q;
  logic              ultimo;

  // Row-major advance; linha_d is only committed when this is not the last quadrant.
  always_comb begin
    linha_d  = linha_q;
    coluna_d = coluna_q + CW'(1);
    if (coluna_q == COL_MAX) begin
      coluna_d = '0;
      linha_d  = linha_q + LW'(1);
    end
    ultimo = (linha_q == LIN_MAX) && (coluna_q == COL_MAX);
    addr_d = ADDR_W'(linha_d) * ADDR_W'(N_COL) + ADDR_W'(coluna_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      linha_q   <= '0;
      coluna_q  <= '0;
      shift_q   <= '1;
      bit_q     <= '0;
      baud_q    <= '0;
      sof_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        INICIAL: begin
          if (iniciar) begin
            estado_q  <= PREPARA;
            ocupado_q <= 1'b1;
          end
        end
        PREPARA: begin
          linha_q  <= '0;
          coluna_q <= '0;
          sof_q    <= 1'b1;
          // Frame is {stop, data, start}; bit 0 drives the line directly.
          shift_q  <= {1'b1, SOF_BYTE, 1'b0};
          bit_q    <= '0;
          baud_q   <= '0;
          estado_q <= TRANSMITE;
        end
        LE_MEMORIA: begin
          rd_en_q  <= 1'b0;
          estado_q <= ESPERA_DADO;
        end
        ESPERA_DADO: estado_q <= CARREGA;
        CARREGA: begin
          shift_q  <= {1'b1, rd_data, 1'b0};
          bit_q    <= '0;
          baud_q   <= '0;
          estado_q <= TRANSMITE;
        end
        TRANSMITE: begin
          if (baud_q == BAUD_MAX) begin
            baud_q  <= '0;
            shift_q <= {1'b1, shift_q[9:1]};
            if (bit_q == 4'd9) begin
              bit_q    <= '0;
              estado_q <= PROXIMO;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        PROXIMO: begin
          if (sof_q) begin
            sof_q     <= 1'b0;
            linha_q   <= '0;
            coluna_q  <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b1;
            estado_q  <= LE_MEMORIA;
          end else if (ultimo) begin
            pronto_q <= 1'b1;
            estado_q <= FIM;
          end else begin
            linha_q   <= linha_d;
            coluna_q  <= coluna_d;
            rd_addr_q <= addr_d;
            rd_en_q   <= 1'b1;
            estado_q  <= LE_MEMORIA;
          end
        end
        FIM: begin
          ocupado_q <= 1'b0;
          estado_q  <= INICIAL;
        end
        default: begin
          estado_q  <= INICIAL;
          ocupado_q <= 1'b0;
          rd_en_q   <= 1'b0;
          shift_q   <= '1;
          sof_q     <= 1'b0;
        end
      endcase
    end
  end

  assign saida_serial = shift_q[0];
  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign db_estado    = estado_q[3] ? 4'hF : 4'(estado_q);
endmodule

// File: tb/tb_quadrant_serial_reader.sv
// Bench for quadrant_serial_reader: cycle table, full-frame line waveform
// against a timing model, UART decode, 2x3 address walk, abort and restart.
`timescale 1ns/1ps
module tb_quadrant_serial_reader;
  localparam int CPB        = 4;
  localparam int NL         = 3, NC = 3, AW = 4;
  localparam int NQ         = NL * NC;
  localparam int FRAME_CYC  = 1 + (1 + NQ) * (10 * CPB + 1) + 3 * NQ + 1;
  localparam int NL2        = 2, NC2 = 3;
  localparam int FRAME2_CYC = 1 + (1 + NL2 * NC2) * (10 * CPB + 1) + 3 * NL2 * NC2 + 1;
  localparam int D0_TX      = 2 + 10 * CPB + 3;
  localparam int ABORT_IDX  = D0_TX + 2 * (10 * CPB + 4) + 3 * CPB + 1;
  localparam logic [7:0] SOF = 8'hAA;

  logic          clock = 1'b0;
  logic          reset, iniciar, iniciar2;
  logic [7:0]    rd_data, rd_data2;
  logic [AW-1:0] rd_addr, rd_addr2;
  logic          rd_en, rd_en2, saida, saida2, ocup, ocup2, pronto, pronto2;
  logic [3:0]    est, est2;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  quadrant_serial_reader #(.N_LIN(NL), .N_COL(NC), .ADDR_W(AW), .CLKS_PER_BIT(CPB), .SOF_BYTE(SOF)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .rd_data(rd_data), .rd_addr(rd_addr),
    .rd_en(rd_en), .saida_serial(saida), .ocupado(ocup), .pronto(pronto), .db_estado(est));

  quadrant_serial_reader #(.N_LIN(NL2), .N_COL(NC2), .ADDR_W(AW), .CLKS_PER_BIT(CPB), .SOF_BYTE(SOF)) dut2 (
    .clock(clock), .reset(reset), .iniciar(iniciar2), .rd_data(rd_data2), .rd_addr(rd_addr2),
    .rd_en(rd_en2), .saida_serial(saida2), .ocupado(ocup2), .pronto(pronto2), .db_estado(est2));

  // Synchronous RAM models; optional noise on rd_data outside the sampling state.
  logic [7:0] mem [16];
  logic [7:0] mem_q  = 8'h00;
  logic [7:0] mem2_q = 8'h00;
  logic [7:0] noise  = 8'h00;
  logic       noise_en = 1'b0;
  always @(posedge clock) begin
    if (rd_en)  mem_q  <= mem[rd_addr];
    if (rd_en2) mem2_q <= 8'(rd_addr2) + 8'h10;
    noise <= 8'($urandom);
  end
  assign rd_data  = (noise_en && est != 4'd4) ? noise : mem_q;
  assign rd_data2 = mem2_q;

  int addr2_log[$];
  int pronto2_cnt = 0;
  always @(negedge clock) begin
    if (rd_en2) addr2_log.push_back(int'(rd_addr2));
    if (pronto2) pronto2_cnt <= pronto2_cnt + 1;
  end

  logic       cap_ser[$], cap_pr[$], cap_oc[$];
  logic [3:0] cap_est[$];
  logic       exp_ser[$];
  logic [7:0] exp_bytes[$], dec_bytes[$];

  typedef struct {
    logic rst; logic ini;
    logic [3:0] est; logic ocup; logic ser; logic ren; logic pr;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic void fill_mem(input bit rnd);
    exp_bytes.delete();
    exp_bytes.push_back(SOF);
    for (int i = 0; i < 16; i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
    for (int i = 0; i < NQ; i++) exp_bytes.push_back(mem[i]);
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < CPB; c++) exp_ser.push_back(f[k]);
  endfunction

  // Expected line from frame rules: prepara, SOF, proximo, then 3 idle + byte + proximo per quadrant, fim.
  function automatic void build_exp(input int span);
    exp_ser.delete();
    exp_ser.push_back(1'b1);
    push_byte(exp_bytes[0]);
    exp_ser.push_back(1'b1);
    for (int j = 1; j < exp_bytes.size(); j++) begin
      for (int c = 0; c < 3; c++) exp_ser.push_back(1'b1);
      push_byte(exp_bytes[j]);
      exp_ser.push_back(1'b1);
    end
    exp_ser.push_back(1'b1);
    while (exp_ser.size() < span) exp_ser.push_back(1'b1);
  endfunction

  function automatic void decode();
    int i;
    int mid;
    logic [7:0] b;
    dec_bytes.delete();
    i = 0;
    while (i + 10 * CPB <= cap_ser.size()) begin
      if (cap_ser[i] === 1'b0) begin
        mid = i + CPB / 2;
        for (int k = 0; k < 8; k++) b[k] = cap_ser[mid + (k + 1) * CPB];
        if (cap_ser[mid + 9 * CPB] === 1'b1) dec_bytes.push_back(b);
        i = i + 10 * CPB;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic clear_caps();
    cap_ser.delete(); cap_pr.delete(); cap_oc.delete(); cap_est.delete();
  endtask

  task automatic sample();
    cap_ser.push_back(saida); cap_pr.push_back(pronto);
    cap_oc.push_back(ocup);   cap_est.push_back(est);
  endtask

  // mode 0: single pulse, 1: held high, 2: random pulses mid-frame only
  task automatic run_frame(input int mode, input int n);
    clear_caps();
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      sample();
      case (mode)
        0:       iniciar = 1'b0;
        1:       iniciar = 1'b1;
        default: iniciar = (i < FRAME_CYC - 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      endcase
    end
    iniciar = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int span);
    int bad, pidx, pcnt, obad;
    build_exp(span);
    bad = -1;
    for (int i = 0; i < span; i++) if (bad < 0 && cap_ser[i] !== exp_ser[i]) bad = i;
    chk({tag, " line first bad cycle"}, bad, -1);
    pcnt = 0; pidx = -1;
    for (int i = 0; i < cap_pr.size(); i++)
      if (cap_pr[i] === 1'b1) begin pcnt++; if (pidx < 0) pidx = i; end
    chk({tag, " pronto count"}, pcnt, 1);
    chk({tag, " pronto cycle"}, pidx + 1, FRAME_CYC);
    obad = -1;
    for (int i = 0; i < span; i++) if (obad < 0 && cap_oc[i] !== (i < FRAME_CYC)) obad = i;
    chk({tag, " ocupado first bad cycle"}, obad, -1);
    decode();
    chk({tag, " byte count"}, dec_bytes.size(), exp_bytes.size());
    for (int j = 0; j < exp_bytes.size(); j++)
      chk($sformatf("%s byte%0d", tag, j), (j < dec_bytes.size()) ? int'(dec_bytes[j]) : -1, int'(exp_bytes[j]));
  endtask

  initial begin
    int cyc, held, pr, p2start, bad2;
    logic [9:0] obs;

    // rows: {rst, ini} -> {state, ocupado, line, rd_en, pronto} after the next edge
    tbl[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int r = 3; r < 15; r++)
      tbl[r] = '{1'b1, 1'(r % 2), 4'd5, 1'b1, (r >= 11), 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b0; iniciar = 1'b0; iniciar2 = 1'b0;
    fill_mem(1'b0);
    repeat (2) @(negedge clock);
    chk("reset rd_addr", int'(rd_addr), 0);

    for (int r = 0; r < 18; r++) begin
      reset = tbl[r].rst; iniciar = tbl[r].ini;
      @(negedge clock);
      chk($sformatf("table row%0d", r), int'({est, ocup, saida, rd_en, pronto}),
          int'({tbl[r].est, tbl[r].ocup, tbl[r].ser, tbl[r].ren, tbl[r].pr}));
    end

    // 2x3 address walk
    addr2_log.delete();
    p2start = pronto2_cnt;
    iniciar2 = 1'b1;
    @(posedge clock);
    @(negedge clock); iniciar2 = 1'b0;
    cyc = 1;
    while (pronto2 !== 1'b1 && cyc < FRAME2_CYC + 20) begin @(negedge clock); cyc++; end
    chk("2x3 pronto cycle", cyc, FRAME2_CYC);
    repeat (3) @(negedge clock);
    chk("2x3 pronto count", pronto2_cnt - p2start, 1);
    chk("2x3 rd_en pulses", addr2_log.size(), NL2 * NC2);
    bad2 = 0;
    foreach (addr2_log[k]) if (addr2_log[k] >= NL2 * NC2) bad2++;
    chk("2x3 addr out of range", bad2, 0);
    for (int k = 0; k < NL2 * NC2; k++)
      chk($sformatf("2x3 addr%0d", k), (k < addr2_log.size()) ? addr2_log[k] : -1, k);

    // baseline frame 0x00..0x08
    fill_mem(1'b0);
    run_frame(0, FRAME_CYC + 3);
    check_frame("base", FRAME_CYC + 3);
    chk("base idle state", int'(est), 0);

    // iniciar held high: back-to-back, and the 0x5A waveform
    fill_mem(1'b1);
    mem[0] = 8'h5A; exp_bytes[1] = 8'h5A;
    run_frame(1, FRAME_CYC + 2);
    check_frame("hold", FRAME_CYC + 1);
    chk("hold inicial after fim", int'(cap_est[FRAME_CYC]), 0);
    chk("hold prepara 2 after pronto", int'(cap_est[FRAME_CYC + 1]), 1);
    obs = '0; held = 0;
    for (int k = 0; k < 10; k++) begin
      obs[k] = cap_ser[D0_TX + k * CPB];
      for (int c = 0; c < CPB; c++) if (cap_ser[D0_TX + k * CPB + c] !== obs[k]) held++;
    end
    chk("5A bit sequence", int'(obs), int'(10'b1010110100));
    chk("5A bit hold", held, 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;

    // random data, random mid-frame iniciar pulses, rd_data noise
    for (int f = 0; f < 3; f++) begin
      fill_mem(1'b1);
      noise_en = (f != 1);
      run_frame((f == 2) ? 0 : 2, FRAME_CYC + 3);
      check_frame($sformatf("rand%0d", f), FRAME_CYC + 3);
    end
    noise_en = 1'b0;

    // abort during third data bit of byte 0x02
    fill_mem(1'b0);
    clear_caps();
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock);
    @(negedge clock); iniciar = 1'b0;
    repeat (ABORT_IDX) @(negedge clock);
    chk("pre-abort line", int'(saida), 0);
    chk("pre-abort state", int'(est), 5);
    #1 reset = 1'b0;
    #1;
    chk("abort line", int'(saida), 1);
    chk("abort state", int'(est), 0);
    chk("abort ocupado", int'(ocup), 0);
    pr = 0;
    repeat (4) begin @(negedge clock); if (pronto) pr++; end
    chk("abort no pronto", pr, 0);
    reset = 1'b1;
    @(negedge clock);
    run_frame(0, FRAME_CYC + 3);
    check_frame("post-abort", FRAME_CYC + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
